cp0_nested_irq: RTL

- Parametrised CP0 successor: interrupt status/mask/EPC register file with prioritised, nested interrupt entry.
- Latches NUM_IRQ request lines and selects the highest-priority unmasked source above the current active level.
- Keeps a NEST_DEPTH-deep EPC and level stack so ERET returns to the interrupted context.
- Sits beside the pipeline's WB stage; the CPU drives the resume PC and ERET and reads/writes CP0 registers by index.

---
 rtl/cp0_nested_irq.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/cp0_nested_irq.sv
// CP0 interrupt controller: STATUS/MASK/EPC/PENDING/DEPTH registers with
// prioritised, nested interrupt entry and an EPC/level stack unwound by ERET.
module cp0_nested_irq #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_IRQ    = 4,
  parameter int unsigned NEST_DEPTH = 3,
  localparam int unsigned VEC_W     = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1,
  localparam int unsigned DEP_W     = $clog2(NEST_DEPTH + 1)
) (
  input  logic               in_CLK,
  input  logic               in_RST_N,
  input  logic               in_WE,
  input  logic [2:0]         in_rW,
  input  logic [DATA_W-1:0]  in_W,
  input  logic [2:0]         in_rA,
  output logic [DATA_W-1:0]  out_A,
  input  logic [NUM_IRQ-1:0] in_IRQ,
  input  logic [DATA_W-1:0]  in_IRQ_PC,
  input  logic               in_stall,
  input  logic               in_eret,
  output logic               out_take,
  output logic [VEC_W-1:0]   out_vector,
  output logic               out_IE,
  output logic [NUM_IRQ-1:0] out_MASK,
  output logic [DATA_W-1:0]  out_EPC,
  output logic [DEP_W-1:0]   out_depth
);

  localparam int unsigned LVL_W = $clog2(NUM_IRQ + 1);
  localparam int unsigned IDX_W = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;

  logic                                ie_q, ie_d;
  logic                                ovf_q, ovf_d;
  logic [NUM_IRQ-1:0]                  mask_q, mask_d;
  logic [NUM_IRQ-1:0]                  pend_q, pend_d;
  logic [NUM_IRQ-1:0]                  irq_prev_q;
  logic [DEP_W-1:0]                    depth_q, depth_d;
  logic [LVL_W-1:0]                    lvl_q, lvl_d;
  logic [NEST_DEPTH-1:0][DATA_W-1:0]   stk_epc_q, stk_epc_d;
  logic [NEST_DEPTH-1:0][LVL_W-1:0]    stk_lvl_q, stk_lvl_d;
  logic                                take_q, take_d;
  logic [VEC_W-1:0]                    vector_q, vector_d;

  logic               depth_nz, full;
  logic [IDX_W-1:0]   top_idx, push_idx;
  logic [DATA_W-1:0]  epc_top;
  logic               any_cand, qual, take, ovf_evt;
  logic [VEC_W-1:0]   win;
  logic [LVL_W-1:0]   win_lvl;
  logic [NUM_IRQ-1:0] win_oh;
  logic               wr_status, wr_mask, wr_epc, wr_pend;

  assign depth_nz = (depth_q != '0);
  assign full     = (depth_q == DEP_W'(NEST_DEPTH));
  assign top_idx  = IDX_W'(depth_q - DEP_W'(1));
  assign push_idx = IDX_W'(depth_q);
  assign epc_top  = depth_nz ? stk_epc_q[top_idx] : '0;

  assign wr_status = in_WE && (in_rW == 3'd0);
  assign wr_mask   = in_WE && (in_rW == 3'd1);
  assign wr_epc    = in_WE && (in_rW == 3'd2);
  assign wr_pend   = in_WE && (in_rW == 3'd3);

  // Highest-index enabled pending source whose level beats the active one
  always_comb begin
    any_cand = 1'b0;
    win      = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (pend_q[i] && mask_q[i] && (LVL_W'(i + 1) > lvl_q)) begin
        any_cand = 1'b1;
        win      = VEC_W'(i);
      end
    end
  end

  assign win_lvl = LVL_W'(win) + LVL_W'(1);
  assign win_oh  = NUM_IRQ'(1) << win;
  assign qual    = any_cand && ie_q && !in_stall && !in_eret;
  assign take    = qual && !full;
  assign ovf_evt = qual && full;

  // Next-state: software writes first, then ERET/take override, edge sets last
  always_comb begin
    ie_d      = ie_q;
    ovf_d     = ovf_q;
    mask_d    = mask_q;
    pend_d    = pend_q;
    depth_d   = depth_q;
    lvl_d     = lvl_q;
    stk_epc_d = stk_epc_q;
    stk_lvl_d = stk_lvl_q;
    take_d    = 1'b0;
    vector_d  = vector_q;

    if (wr_status) begin
      ie_d  = in_W[0];
      ovf_d = in_W[1];
    end
    if (wr_mask) mask_d = in_W[NUM_IRQ-1:0];
    if (wr_pend) pend_d = pend_q & ~in_W[NUM_IRQ-1:0];
    if (wr_epc && depth_nz && !take) stk_epc_d[top_idx] = in_W;
    if (ovf_evt) ovf_d = 1'b1;

    if (in_eret) begin
      ie_d = 1'b1;
      if (depth_nz) begin
        lvl_d              = stk_lvl_q[top_idx];
        stk_epc_d[top_idx] = '0;
        stk_lvl_d[top_idx] = '0;
        depth_d            = depth_q - DEP_W'(1);
      end
    end else if (take) begin
      stk_epc_d[push_idx] = in_IRQ_PC;
      stk_lvl_d[push_idx] = lvl_q;
      depth_d             = depth_q + DEP_W'(1);
      lvl_d               = win_lvl;
      pend_d              = pend_d & ~win_oh;
      ie_d                = 1'b0;
      take_d              = 1'b1;
      vector_d            = win;
    end

    pend_d = pend_d | (in_IRQ & ~irq_prev_q);
  end

  always_ff @(posedge in_CLK or negedge in_RST_N) begin
    if (!in_RST_N) begin
      ie_q       <= 1'b1;
      ovf_q      <= 1'b0;
      mask_q     <= '0;
      pend_q     <= '0;
      irq_prev_q <= '0;
      depth_q    <= '0;
      lvl_q      <= '0;
      stk_epc_q  <= '0;
      stk_lvl_q  <= '0;
      take_q     <= 1'b0;
      vector_q   <= '0;
    end else begin
      ie_q       <= ie_d;
      ovf_q      <= ovf_d;
      mask_q     <= mask_d;
      pend_q     <= pend_d;
      irq_prev_q <= in_IRQ;
      depth_q    <= depth_d;
      lvl_q      <= lvl_d;
      stk_epc_q  <= stk_epc_d;
      stk_lvl_q  <= stk_lvl_d;
      take_q     <= take_d;
      vector_q   <= vector_d;
    end
  end

  // Register read port
  always_comb begin
    out_A = '0;
    case (in_rA)
      3'd0:    out_A = DATA_W'({ovf_q, ie_q});
      3'd1:    out_A = DATA_W'(mask_q);
      3'd2:    out_A = epc_top;
      3'd3:    out_A = DATA_W'(pend_q);
      3'd4:    out_A = DATA_W'(depth_q);
      default: out_A = '0;
    endcase
  end

  assign out_take   = take_q;
  assign out_vector = vector_q;
  assign out_IE     = ie_q;
  assign out_MASK   = mask_q;
  assign out_EPC    = epc_top;
  assign out_depth  = depth_q;

endmodule
